// File: rtl/mem_burst_responder_pkg.sv
// rtl/mem_burst_responder_pkg.sv - shared block geometry, timing default and burst FSM states
// Also imported by the cache refill requester so both sides agree on block shape.
package mem_burst_responder_pkg;

    localparam int BLOCK_OFFSET_BITS = 3;
    localparam int BLOCK_WORDS       = 1 << BLOCK_OFFSET_BITS;
    localparam int LATENCY_DEFAULT   = 4;
    localparam int WORDS_DEFAULT     = 4096;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_BURST
    } burst_state_e;

endpackage

// File: rtl/mem_word_array.sv
// rtl/mem_word_array.sv - word-wide backing store with one write port and one combinational read port
// Contents are never reset so a preload survives a control reset.
module mem_word_array #(
    parameter int WORDS = 4096
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(WORDS)-1:0] wr_index,
    input  logic [31:0]              wr_data,
    input  logic [$clog2(WORDS)-1:0] rd_index,
    output logic [31:0]              rd_data
);

    logic [31:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_index] <= wr_data;
        end
    end

    assign rd_data = mem[rd_index];

endmodule

// File: rtl/mem_burst_responder.sv
// rtl/mem_burst_responder.sv - critical-word-first block refill responder over a word array
// Outputs are registered, so a word read in BURST appears on the pins one cycle later.
module mem_burst_responder
    import mem_burst_responder_pkg::*;
#(
    parameter int WORDS   = WORDS_DEFAULT,
    parameter int OFFSET  = BLOCK_OFFSET_BITS,
    parameter int LATENCY = LATENCY_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        request,
    input  logic [31:0] request_addr,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    output logic        busy,
    output logic        data_valid,
    output logic [31:0] data,
    output logic [31:0] data_addr,
    output logic        last,
    output logic        dropped
);

    localparam int AW = $clog2(WORDS);
    localparam int BW = 30 - OFFSET;
    localparam logic [3:0] WAIT_LOAD = 4'(LATENCY - 1);

    burst_state_e      state_q, state_d;
    logic [BW-1:0]     base_q, base_d;
    logic [OFFSET-1:0] off_q, off_d;
    logic [OFFSET-1:0] beat_q, beat_d;
    logic [3:0]        wait_q, wait_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              dropped_q, dropped_d;
    logic [31:0]       data_q, data_d;
    logic [31:0]       addr_q, addr_d;

    logic [31:0]       rd_addr;
    logic [31:0]       rd_data;
    logic              unused_addr_bits;

    assign rd_addr = {base_q, off_q, 2'b00};
    assign unused_addr_bits = ^{request_addr[1:0], wr_addr[1:0], wr_addr[31:AW+2]};

    mem_word_array #(
        .WORDS(WORDS)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_index(wr_addr[AW+1:2]),
        .wr_data (wr_data),
        .rd_index(rd_addr[AW+1:2]),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        off_d     = off_q;
        beat_d    = beat_q;
        wait_d    = wait_q;
        valid_d   = 1'b0;
        last_d    = 1'b0;
        data_d    = '0;
        addr_d    = '0;
        // busy_q still covers the last-word cycle, so a request there is dropped too
        dropped_d = request && busy_q;

        case (state_q)
            ST_IDLE: begin
                if (request && !stall && !busy_q) begin
                    base_d  = request_addr[31:OFFSET+2];
                    off_d   = request_addr[OFFSET+1:2];
                    beat_d  = '0;
                    wait_d  = WAIT_LOAD;
                    state_d = (LATENCY == 1) ? ST_BURST : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!stall) begin
                    wait_d = wait_q - 4'd1;
                    if (wait_q == 4'd1) begin
                        state_d = ST_BURST;
                    end
                end
            end
            ST_BURST: begin
                if (!stall) begin
                    valid_d = 1'b1;
                    data_d  = rd_data;
                    addr_d  = rd_addr;
                    last_d  = (beat_q == '1);
                    off_d   = off_q + 1'b1;
                    beat_d  = beat_q + 1'b1;
                    if (beat_q == '1) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE) || valid_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            base_q    <= '0;
            off_q     <= '0;
            beat_q    <= '0;
            wait_q    <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            dropped_q <= 1'b0;
            data_q    <= '0;
            addr_q    <= '0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            off_q     <= off_d;
            beat_q    <= beat_d;
            wait_q    <= wait_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            dropped_q <= dropped_d;
            data_q    <= data_d;
            addr_q    <= addr_d;
        end
    end

    assign busy       = busy_q;
    assign data_valid = valid_q;
    assign data       = data_q;
    assign data_addr  = addr_q;
    assign last       = last_q;
    assign dropped    = dropped_q;

endmodule

// File: tb/tb_mem_burst_responder.sv
// tb/tb_mem_burst_responder.sv - directed table-driven bench for mem_burst_responder
module tb_mem_burst_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        request;
    logic        request1;
    logic [31:0] request_addr;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    logic        busy, dv, last, dropped;
    logic [31:0] data, daddr;
    logic        busy1, dv1, last1, dropped1;
    logic [31:0] data1, daddr1;

    int total = 0;
    int bad   = 0;

    logic        cv [0:31];
    logic        cl [0:31];
    logic        cb [0:31];
    logic [31:0] cd [0:31];
    logic [31:0] ca [0:31];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] base;
        int          first_off;
        int          first_k;
        int          last_k;
        int          stall_edge;
        int          stall_len;
        int          req2_edge;
        int          req3_edge;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    mem_burst_responder #(.WORDS(4096), .OFFSET(3), .LATENCY(4)) dut (
        .clk(clk), .reset(reset), .stall(stall), .request(request),
        .request_addr(request_addr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .data_valid(dv), .data(data), .data_addr(daddr),
        .last(last), .dropped(dropped)
    );

    mem_burst_responder #(.WORDS(4096), .OFFSET(3), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .stall(stall), .request(request1),
        .request_addr(request_addr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy1), .data_valid(dv1), .data(data1), .data_addr(daddr1),
        .last(last1), .dropped(dropped1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " data_valid"}, 32'(dv), 0);
        check({tag, " last"}, 32'(last), 0);
        check({tag, " dropped"}, 32'(dropped), 0);
        check({tag, " data"}, data, 0);
        check({tag, " data_addr"}, daddr, 0);
    endtask

    // Called at a negedge; leaves inputs quiet at a negedge.
    task automatic do_vec(input int vi, input vec_t v);
        int  n;
        int  w;
        bit  exp_valid;
        bit  stalled;
        n = 0;
        stall = 1'b0;
        request = 1'b1;
        request_addr = v.addr;
        @(posedge clk);
        for (int k = 0; k <= v.last_k + 2; k++) begin
            @(negedge clk);
            request = 1'b0;
            stalled = (v.stall_len > 0) && (k >= v.stall_edge) && (k < v.stall_edge + v.stall_len);
            exp_valid = (k >= v.first_k) && (k <= v.last_k) && !stalled;
            check($sformatf("v%0d k%0d data_valid", vi, k), 32'(dv), 32'(exp_valid));
            if (exp_valid && dv) begin
                w = (v.first_off + n) & 7;
                check($sformatf("v%0d k%0d data", vi, k), data, 32'hA0 + 32'(w));
                check($sformatf("v%0d k%0d data_addr", vi, k), daddr, v.base + 32'(4 * w));
                check($sformatf("v%0d k%0d last", vi, k), 32'(last), 32'(n == 7));
                n++;
            end else if (!exp_valid) begin
                check($sformatf("v%0d k%0d idle data", vi, k), data, 0);
                check($sformatf("v%0d k%0d idle addr", vi, k), daddr, 0);
                check($sformatf("v%0d k%0d idle last", vi, k), 32'(last), 0);
            end
            check($sformatf("v%0d k%0d busy", vi, k), 32'(busy), 32'(k <= v.last_k));
            check($sformatf("v%0d k%0d dropped", vi, k), 32'(dropped),
                  32'((k > 0) && (k == v.req2_edge || k == v.req3_edge)));
            stall   = (v.stall_len > 0) && (k + 1 >= v.stall_edge) && (k + 1 < v.stall_edge + v.stall_len);
            request = (k + 1 == v.req2_edge) || (k + 1 == v.req3_edge);
        end
        check($sformatf("v%0d word count", vi), 32'(n), 8);
        stall = 1'b0;
        request = 1'b0;
    endtask

    task automatic capture(input bit sel, input logic [31:0] addr, input int ncyc,
                           input int wr_edge, input logic [31:0] wa, input logic [31:0] wd);
        if (sel) request1 = 1'b1;
        else     request  = 1'b1;
        request_addr = addr;
        wr_addr = wa;
        wr_data = wd;
        wr_en = (wr_edge == 0);
        @(posedge clk);
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            request  = 1'b0;
            request1 = 1'b0;
            cv[k] = sel ? dv1    : dv;
            cd[k] = sel ? data1  : data;
            ca[k] = sel ? daddr1 : daddr;
            cl[k] = sel ? last1  : last;
            cb[k] = sel ? busy1  : busy;
            wr_en = (k + 1 == wr_edge);
        end
        wr_en = 1'b0;
    endtask

    initial begin
        vecs[0] = '{32'h0000_0100, 32'h0000_0100, 0, 4, 11, -1, 0, -1, -1};
        vecs[1] = '{32'h0000_0116, 32'h0000_0100, 5, 4, 11, -1, 0, -1, -1};
        vecs[2] = '{32'h0000_0100, 32'h0000_0100, 0, 4, 13,  7, 2, -1, -1};
        vecs[3] = '{32'h0000_0100, 32'h0000_0100, 0, 4, 11, -1, 0,  2, 12};
        vecs[4] = '{32'h0000_411C, 32'h0000_4100, 7, 4, 12, 11, 1, -1, -1};
        vecs[5] = '{32'h0000_0108, 32'h0000_0100, 2, 7, 14,  2, 3, -1, -1};

        reset = 1'b0;
        stall = 1'b0;
        request = 1'b0;
        request1 = 1'b0;
        request_addr = '0;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;

        @(negedge clk);
        check_idle_outputs("reset");

        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1;
            wr_addr = 32'h100 + 32'(4 * i);
            wr_data = 32'hA0 + 32'(i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        reset = 1'b1;

        for (int i = 0; i < 6; i++) begin
            do_vec(i, vecs[i]);
        end

        request = 1'b1;
        stall = 1'b1;
        request_addr = 32'h100;
        @(negedge clk);
        check("stalled request busy", 32'(busy), 0);
        check("stalled request dropped", 32'(dropped), 0);
        request = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        check("stalled request stays idle", 32'(busy), 0);

        capture(1'b1, 32'h100, 11, -1, 32'h0, 32'h0);
        for (int k = 0; k < 11; k++) begin
            check($sformatf("lat1 k%0d data_valid", k), 32'(cv[k]), 32'((k >= 1) && (k <= 8)));
            check($sformatf("lat1 k%0d busy", k), 32'(cb[k]), 32'(k <= 8));
            if (k >= 1 && k <= 8) begin
                check($sformatf("lat1 k%0d data", k), cd[k], 32'hA0 + 32'(k - 1));
                check($sformatf("lat1 k%0d data_addr", k), ca[k], 32'h100 + 32'(4 * (k - 1)));
                check($sformatf("lat1 k%0d last", k), 32'(cl[k]), 32'(k == 8));
            end
        end

        capture(1'b0, 32'h100, 14, 4, 32'h100, 32'h55);
        check("same-cycle write old word0", cd[4], 32'hA0);
        check("same-cycle write valid", 32'(cv[4]), 1);
        check("same-cycle write word1", cd[5], 32'hA1);
        capture(1'b0, 32'h100, 14, -1, 32'h0, 32'h0);
        check("backdoor new word0", cd[4], 32'h55);
        check("backdoor word7", cd[11], 32'hA7);
        check("backdoor last", 32'(cl[11]), 1);
        wr_en = 1'b1;
        wr_addr = 32'h100;
        wr_data = 32'hA0;
        @(negedge clk);
        wr_en = 1'b0;

        request = 1'b1;
        request_addr = 32'h100;
        @(posedge clk);
        #1 request = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("pre-abort data_valid", 32'(dv), 1);
        check("pre-abort data", data, 32'hA2);
        #2 reset = 1'b0;
        #1 check_idle_outputs("async reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("aborted k%0d data_valid", k), 32'(dv), 0);
            check($sformatf("aborted k%0d busy", k), 32'(busy), 0);
        end
        do_vec(6, vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
